// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, 32-entry FWFT byte FIFO.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_receiver #(
   parameter int CLOCK_HZ = 1_843_200
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       uart_rx_i,
   input  logic [1:0] baudrate_select_i,
   input  logic [5:0] data_buffer_avail_tresh_i,
   input  logic       data_read_i,
   output logic [7:0] data_o,
   output logic       data_buffer_empty_o,
   output logic       data_buffer_avail_o,
   output logic [5:0] data_count_o,
   output logic       frame_error_o,
   output logic       overrun_o
);

   localparam int DIV0 = CLOCK_HZ / (16 * 9600);
   localparam int DIV1 = CLOCK_HZ / (16 * 19200);
   localparam int DIV2 = CLOCK_HZ / (16 * 57600);
   localparam int DIV3 = CLOCK_HZ / (16 * 115200);
   localparam int CW   = (DIV0 > 1) ? $clog2(DIV0 + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   logic          sync1_q, sync2_q, rx_prev_q, rx_s;
   state_t        state_q, state_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d, div_m1;
   logic [1:0]    baud_q, baud_d;
   logic [3:0]    scnt_q, scnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [4:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [5:0]    count_q, count_d;
   logic          frame_error_q, frame_error_d;
   logic          overrun_q, overrun_d;
   logic          tick, push, pop, wr_en;
   logic [7:0]    mem_q [32];

   assign rx_s = sync2_q;

   always_comb begin
      case (baud_q)
         2'd0:    div_m1 = CW'(DIV0 - 1);
         2'd1:    div_m1 = CW'(DIV1 - 1);
         2'd2:    div_m1 = CW'(DIV2 - 1);
         default: div_m1 = CW'(DIV3 - 1);
      endcase
   end

   assign tick = (tick_cnt_q == div_m1);

   always_comb begin
      state_d       = state_q;
      tick_cnt_d    = tick ? '0 : tick_cnt_q + CW'(1);
      baud_d        = baud_q;
      scnt_d        = scnt_q;
      bit_d         = bit_q;
      shift_d       = shift_q;
      push          = 1'b0;
      frame_error_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s && rx_prev_q) begin
               state_d    = S_START;
               tick_cnt_d = '0;
               scnt_d     = '0;
               baud_d     = baudrate_select_i;
            end
         end
         S_START: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd7) begin
                  // a start bit that is high again at mid-bit was a glitch
                  scnt_d  = '0;
                  bit_d   = '0;
                  state_d = rx_s ? S_IDLE : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  shift_d = {rx_s, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               scnt_d = scnt_q + 4'd1;
               if (scnt_q == 4'd15) begin
                  if (rx_s) begin
                     push    = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     frame_error_d = 1'b1;
                     state_d       = S_BREAK;
                  end
               end
            end
         end
         S_BREAK: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the head is popped in the same cycle.
   always_comb begin
      pop       = data_read_i && (count_q != 6'd0);
      wr_en     = push && ((count_q != 6'd32) || pop);
      overrun_d = push && (count_q == 6'd32) && !pop;
      wr_ptr_d  = wr_en ? wr_ptr_q + 5'd1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 5'd1 : rd_ptr_q;
      count_d   = count_q;
      if (wr_en && !pop)      count_d = count_q + 6'd1;
      else if (!wr_en && pop) count_d = count_q - 6'd1;
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         rx_prev_q     <= 1'b1;
         state_q       <= S_IDLE;
         tick_cnt_q    <= '0;
         baud_q        <= '0;
         scnt_q        <= '0;
         bit_q         <= '0;
         shift_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         sync1_q       <= uart_rx_i;
         sync2_q       <= sync1_q;
         rx_prev_q     <= rx_s;
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         baud_q        <= baud_d;
         scnt_q        <= scnt_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= shift_q;
   end

   assign data_buffer_empty_o = (count_q == 6'd0);
   assign data_o              = data_buffer_empty_o ? 8'h00 : mem_q[rd_ptr_q];
   assign data_buffer_avail_o = (count_q >= data_buffer_avail_tresh_i);
   assign data_count_o        = count_q;
   assign frame_error_o       = frame_error_q;
   assign overrun_o           = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames from a bit-level transmitter model,
// expected bytes queued in a scoreboard and checked by a monitor on every pop.
module tb_uart_receiver;

   logic       clock_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       uart_rx_i = 1'b1;
   logic [1:0] baudrate_select_i = 2'd3;
   logic [5:0] data_buffer_avail_tresh_i = 6'd16;
   logic       data_read_i = 1'b0;
   logic [7:0] data_o;
   logic       data_buffer_empty_o, data_buffer_avail_o, frame_error_o, overrun_o;
   logic [5:0] data_count_o;

   uart_receiver dut (
      .clock_i(clock_i), .reset_i(reset_i), .uart_rx_i(uart_rx_i),
      .baudrate_select_i(baudrate_select_i),
      .data_buffer_avail_tresh_i(data_buffer_avail_tresh_i),
      .data_read_i(data_read_i), .data_o(data_o),
      .data_buffer_empty_o(data_buffer_empty_o), .data_buffer_avail_o(data_buffer_avail_o),
      .data_count_o(data_count_o), .frame_error_o(frame_error_o), .overrun_o(overrun_o)
   );

   always #5 clock_i = ~clock_i;

   int checks = 0, errors = 0;
   int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic int div_of(input logic [1:0] sel);
      int baud;
      case (sel)
         2'd0: baud = 9600;
         2'd1: baud = 19200;
         2'd2: baud = 57600;
         default: baud = 115200;
      endcase
      return 1843200 / (16 * baud);
   endfunction

   // Reference: what the receiver should do with one whole frame.
   task automatic model_frame(input logic [7:0] d, input bit good, input bit rd_same);
      if (!good) fe_exp++;
      else if (exp_q.size() < 32 || rd_same) exp_q.push_back(d);
      else ov_exp++;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_v);
      int p;
      p = 16 * div_of(baudrate_select_i);
      uart_rx_i = 1'b0;
      repeat (p) @(posedge clock_i);
      #1;
      for (int i = 0; i < 8; i++) begin
         uart_rx_i = d[i];
         repeat (p) @(posedge clock_i);
         #1;
      end
      uart_rx_i = stop_v;
      repeat (p) @(posedge clock_i);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock_i);
      #1;
   endtask

   task automatic read_n(input int n);
      data_read_i = 1'b1;
      repeat (n) @(posedge clock_i);
      #1;
      data_read_i = 1'b0;
   endtask

   // Monitor: counts flag pulses and checks every byte actually popped.
   always @(negedge clock_i) begin
      if (!reset_i) begin
         if (frame_error_o) fe_seen++;
         if (overrun_o) ov_seen++;
         if (data_read_i && !data_buffer_empty_o) begin
            if (exp_q.size() == 0) chk("pop_with_empty_model", 1, 0);
            else chk("rx_byte", data_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [7:0] d;
      bit good;
      int n;

      // reset and idle
      idle(3);
      chk("rst_empty", data_buffer_empty_o, 1);
      chk("rst_count", data_count_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_avail", data_buffer_avail_o, 0);
      chk("rst_flags", {frame_error_o, overrun_o}, 0);
      reset_i = 1'b0;
      idle(1000);
      chk("idle_fe", fe_seen, 0);
      chk("idle_ov", ov_seen, 0);
      chk("idle_empty", data_buffer_empty_o, 1);
      chk("idle_count", data_count_o, 0);
      chk("idle_data", data_o, 0);

      // single byte at select 3 with exact latency
      baudrate_select_i = 2'd3;
      model_frame(8'hA5, 1, 0);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (154) @(posedge clock_i);
            @(negedge clock_i);
            chk("lat_early_count", data_count_o, 0);
            @(posedge clock_i);
            @(negedge clock_i);
            chk("lat_count", data_count_o, 1);
            chk("lat_data", data_o, 8'hA5);
         end
      join
      idle(4);
      read_n(1);
      chk("after_pop_empty", data_buffer_empty_o, 1);

      // fill and overrun at select 2
      baudrate_select_i = 2'd2;
      data_buffer_avail_tresh_i = 6'd32;
      for (int i = 0; i <= 32; i++) begin
         model_frame(8'(i), 1, 0);
         send_frame(8'(i), 1'b1);
         if (i == 30) chk("avail_below", data_buffer_avail_o, 0);
         if (i == 31) begin
            chk("avail_at_32", data_buffer_avail_o, 1);
            chk("count_32", data_count_o, 32);
         end
      end
      idle(4);
      chk("overrun_pulses", ov_seen, ov_exp);
      chk("count_after_ovr", data_count_o, 32);
      read_n(34);
      chk("drain_count", data_count_o, 0);
      chk("drain_empty", data_buffer_empty_o, 1);
      chk("drain_data", data_o, 0);

      // frame error, held-low break, recovery, glitch at select 1
      baudrate_select_i = 2'd1;
      data_buffer_avail_tresh_i = 6'd16;
      model_frame(8'h3C, 0, 0);
      send_frame(8'h3C, 1'b0);
      idle(3 * 96);
      uart_rx_i = 1'b1;
      idle(2 * 96);
      chk("fe_pulses", fe_seen, fe_exp);
      chk("fe_no_push", data_count_o, 0);
      model_frame(8'h3C, 1, 0);
      send_frame(8'h3C, 1'b1);
      idle(4);
      chk("recover_count", data_count_o, 1);
      read_n(1);
      uart_rx_i = 1'b0;
      idle(2);
      uart_rx_i = 1'b1;
      idle(2 * 96);
      chk("glitch_count", data_count_o, 0);
      chk("glitch_fe", fe_seen, fe_exp);
      chk("glitch_ov", ov_seen, ov_exp);

      // randomized frames, baud rates, gaps, errors and reads
      data_buffer_avail_tresh_i = 6'd4;
      for (int k = 0; k < 16; k++) begin
         baudrate_select_i = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         good = ($urandom_range(0, 5) != 0);
         model_frame(d, good, 0);
         send_frame(d, good);
         if (!good) begin
            uart_rx_i = 1'b1;
            idle(2 + $urandom_range(0, 4));
         end else begin
            idle($urandom_range(0, 3));
         end
         if ($urandom_range(0, 1) == 1) read_n(1);
      end
      idle(4);
      chk("rand_count", data_count_o, exp_q.size());
      chk("rand_avail", data_buffer_avail_o, int'(exp_q.size() >= 4));
      chk("rand_fe", fe_seen, fe_exp);
      chk("rand_ov", ov_seen, ov_exp);
      n = exp_q.size();
      read_n(n + 1);
      chk("rand_drain", data_count_o, 0);

      // full FIFO with a pop in the very cycle of the push
      baudrate_select_i = 2'd3;
      for (int i = 0; i < 32; i++) begin
         d = 8'($urandom);
         model_frame(d, 1, 0);
         send_frame(d, 1'b1);
      end
      chk("full_count", data_count_o, 32);
      model_frame(8'hE7, 1, 1);
      fork
         send_frame(8'hE7, 1'b1);
         begin
            repeat (154) @(posedge clock_i);
            #1 data_read_i = 1'b1;
            @(posedge clock_i);
            #1 data_read_i = 1'b0;
         end
      join
      idle(4);
      chk("simul_count", data_count_o, 32);
      chk("simul_no_ovr", ov_seen, ov_exp);
      read_n(33);
      chk("simul_drain", data_count_o, 0);

      // reset during data bit 4, then a clean 0x81
      baudrate_select_i = 2'd2;
      d = 8'h3C;
      uart_rx_i = 1'b0;
      idle(32);
      for (int i = 0; i < 4; i++) begin
         uart_rx_i = d[i];
         idle(32);
      end
      uart_rx_i = d[4];
      idle(16);
      reset_i = 1'b1;
      idle(3);
      chk("midrst_empty", data_buffer_empty_o, 1);
      chk("midrst_count", data_count_o, 0);
      reset_i = 1'b0;
      uart_rx_i = 1'b1;
      idle(64);
      model_frame(8'h81, 1, 0);
      send_frame(8'h81, 1'b1);
      idle(4);
      chk("midrst_rx_count", data_count_o, 1);
      chk("midrst_rx_data", data_o, 8'h81);
      read_n(1);
      chk("midrst_final_empty", data_buffer_empty_o, 1);
      chk("midrst_fe", fe_seen, fe_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the UART block. Recovers 8N1 frames from the serial input using 16x oversampling with mid-bit sampling, and queues received bytes in a 32-entry FIFO read by the host side. Baud selection uses the same 2-bit code as the transmitter, so one select value configures both directions. Framing errors and FIFO overruns are flagged as one-cycle pulses.

## Interface
- CLOCK_HZ, 1_843_200: clock frequency, used to derive the oversample divisors.
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- uart_rx_i  in  1  serial input; idles high; asynchronous to clock_i.
- baudrate_select_i  in  2  baud rate code: 0=9600, 1=19200, 2=57600, 3=115200.
- data_buffer_avail_tresh_i  in  6  FIFO fill level at which data_buffer_avail_o asserts; range 1..32.
- data_read_i  in  1  pops the FIFO head; ignored when the FIFO is empty.
- data_o  out  8  FIFO head byte, first-word fall-through; 0 when empty.
- data_buffer_empty_o  out  1  FIFO holds no bytes.
- data_buffer_avail_o  out  1  FIFO count >= data_buffer_avail_tresh_i.
- data_count_o  out  6  FIFO occupancy, 0..32.
- frame_error_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: byte dropped because the FIFO was full.

## Operation
- **Input synchronizer**
  - uart_rx_i passes through a 2-flop synchronizer; both flops reset to 1.
  - All logic below uses the synchronized value, called rx_s.
- **Tick generator**
  - DIV = CLOCK_HZ / (16 × baud), integer floor. At the default CLOCK_HZ this gives 12, 6, 2, 1.
  - Counter runs 0..DIV-1. A tick is produced when the counter equals DIV-1.
  - The counter clears on start-edge detection.
  - baudrate_select_i is latched on start-edge detection, so changing it mid-frame has no effect until the next frame.
- **State machine** (one-hot or encoded; reset state IDLE):
  - IDLE: when rx_s is 0 and its previous value was 1, go to START and clear the tick and sample counters.
  - START: after 8 ticks, sample rx_s. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE with no flags.
  - DATA: every 16 ticks, sample rx_s into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample rx_s.
    - If 1: push the byte (or flag an overrun) and return to IDLE.
    - If 0: pulse frame_error_o, discard the byte, and go to BREAK.
  - BREAK: wait until rx_s is 1, then go to IDLE. This prevents a held-low line from re-triggering START.
- **FIFO**
  - 32 entries × 8 bits, with 5-bit read and write pointers that wrap 31→0. Count is 6 bits.
  - A push when the FIFO is full drops the byte and pulses overrun_o, unless data_read_i is asserted in the same cycle. In that case the pop and push both occur, count stays 32, and there is no overrun.
  - Simultaneous push and pop at any other level leaves count unchanged.
  - A pop when empty is ignored; count does not underflow.
- **Reset** (asynchronous, any time, including mid-frame):
  - State returns to IDLE; tick counter, shift register, pointers and count are set to 0.
  - Every output is 0 except data_buffer_empty_o, which is 1.
  - A partial frame is lost. After release, a line that is already low does not start a frame until a 1→0 edge is seen.

## Timing
- Let P = 16 × DIV clocks (one bit period) and let t0 be the cycle in which the start edge is detected on rx_s.
- rx_s lags uart_rx_i by 2 cycles.
- Sample points:
  - start bit: t0 + 8·DIV
  - data bit i: t0 + 8·DIV + (i+1)·P
  - stop bit: t0 + 8·DIV + 9·P
- The FIFO write, overrun_o and frame_error_o are registered on the cycle after the stop sample.
- data_buffer_empty_o, data_count_o, data_buffer_avail_o and data_o reflect the write in that same cycle, so the byte is visible 1 cycle after the stop sample.
- A pop takes effect at the clock edge where data_read_i=1. The next head byte is on data_o in the following cycle.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after the stop sample. No minimum idle time is required.
- Tolerance: a frame sampled correctly with transmitter baud error up to ±3%.

## Test plan
- Reset and idle: assert reset_i with uart_rx_i=1, then release it. Required: data_buffer_empty_o=1, data_count_o=0, data_o=0, no flag pulses for 1000 cycles.
- Single byte at select 3 (DIV=1): drive frame 0xA5. Required: data_o=0xA5 and data_count_o=1 exactly 2 + 8 + 144 + 1 cycles after the start edge on uart_rx_i; data_read_i then gives data_buffer_empty_o=1.
- Fill and overrun at select 2: send bytes 0..32 back-to-back with data_buffer_avail_tresh_i=32 and no reads. Required: data_buffer_avail_o rises after byte 31 and data_count_o=32; byte 32 pulses overrun_o once; reading out all entries yields 0..31 in order.
- Frame error and glitch at select 1:
  - Frame 0x3C with stop bit low: one frame_error_o pulse, no push. Holding the line low for 3P produces no further frames; a good 0x3C after the line returns high is received.
  - A 2-cycle low pulse on an idle line: no push, no flags.
- Full with simultaneous read: with the FIFO full (32), complete a byte in the same cycle data_read_i=1. Required: no overrun_o, count stays 32, and the new byte is at the tail.
- Reset mid-frame: assert reset_i during data bit 4 of a frame, release it, then send 0x81. Required: only 0x81 is received and the FIFO count is 1.
